exp_aligner: RTL and testbench
==============================

Name: exp_aligner

Overview:
- Sequential exponent-alignment stage for the single-precision adder datapath. Sits directly after the exponent-mismatch comparator.
- On `start`, captures two IEEE-754 operands and right-shifts the mantissa with the smaller exponent one bit per cycle until both exponents match.
- Presents sign bits, the common exponent and two 27-bit aligned mantissas to the add/normalise stage.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width.
- MAX_SHIFT, 26, maximum shift steps; larger exponent differences are clipped to this value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- A  input  32  operand A, IEEE-754 single.
- B  input  32  operand B, IEEE-754 single.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- SA  output  1  sign of A.
- SB  output  1  sign of B.
- E  output  8  common (larger) exponent.
- MA  output  27  aligned mantissa A: {hidden, 23 fraction, guard, round, sticky}.
- MB  output  27  aligned mantissa B, same format.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state IDLE; busy=0, done=0, SA=0, SB=0, E=0, MA=0, MB=0. Reset asserted mid-operation aborts immediately; no done pulse.
- Operand decode:
  - hidden bit = 1 if exponent field != 0, else 0.
  - effective exponent = 1 when field = 0 (denormal).
  - mantissa register loads as {hidden, frac, 3'b000}.
- States IDLE, SHIFT, DONE.
- IDLE:
  - start=0: remain in IDLE.
  - start=1, at that edge: load SA, SB, both mantissas and E = max(effective exponents).
  - Compute diff = |EA-EB|; cnt = min(diff, MAX_SHIFT).
  - Go to SHIFT if cnt != 0, else DONE.
- SHIFT, each edge:
  - Shift the smaller-exponent mantissa right by 1.
  - New bit0 = old bit1 OR old bit0 (sticky accumulates).
  - cnt decrements; go to DONE when cnt reaches 0.
  - The larger-exponent mantissa is never touched.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs hold until the next accepted start.
- Latency: done is high in the cycle after the (cnt+1)-th rising edge, counting the start edge as the first. Bounded at MAX_SHIFT+1 edges.
- start while busy (SHIFT or DONE): ignored; inputs are not re-sampled.
- Equal exponents: no shifting; MA and MB equal the loaded values.
- Ties: if EA == EB, neither mantissa shifts.
- Zero operand: exponent 0 with hidden 0 aligns like any denormal; its mantissa stays 0.
- Special values (exponent 0xFF) are not detected; they align arithmetically. Downstream handles them.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALIGN_STEP4_EN.
- Defined: each SHIFT cycle shifts by s = min(cnt, 4). All s shifted-out bits OR into sticky; cnt decreases by s. Worst-case latency becomes ceil(MAX_SHIFT/4)+1 edges. Final MA/MB/E are bit-identical to the undefined build.
- Undefined: 1-bit-per-cycle shifter as described above.

Test Plan:
- Equal exponents: A=0x3F800000, B=0x3F800000, start for one cycle -> done in the cycle after the start edge. Outputs E=0x7F, MA=MB=0x4000000, SA=SB=0.
- One-step shift: A=0x40000000, B=0xBF800000 -> done after 2 edges. Outputs E=0x80, MA=0x4000000, MB=0x2000000, SB=1.
- Large difference: A=0x3F800000, B=0x4B800000 (diff 24) -> done after 25 edges. Outputs E=0x97, MA=0x0000004, MB=0x4000000.
- Clipping and sticky: A=0x3F800001, B=0x7F000000 (diff 127) -> done after 27 edges (cnt clipped to 26). Outputs E=0xFE, MA=0x0000001, MB=0x4000000.
- Busy ignore: start A=0x40000000, B=0x3F800000; re-pulse start with different operands while busy=1 -> second request ignored, results match the first pair. Then assert rst mid-SHIFT -> all outputs 0 asynchronously, busy=0, no done pulse.
- Denormal: A=0x00000001, B=0x00800000 -> diff 0, done after the start edge. Outputs E=0x01, MA=0x0000008, MB=0x4000000. Repeat the clipping case with ALIGN_STEP4_EN defined -> identical outputs, done after 8 edges.

Source files
------------

// File: rtl/exp_aligner.sv
// ============================================================================
// exp_aligner : sequential exponent-alignment stage for the FP32 adder path.
// Optional macro ALIGN_STEP4_EN: shift up to 4 bits per SHIFT cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exp_aligner #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int MAX_SHIFT = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 SA,
  output logic                 SB,
  output logic [EXP_W-1:0]     E,
  output logic [MAN_W+3:0]     MA,
  output logic [MAN_W+3:0]     MB
);

  localparam int MW = MAN_W + 4;
  localparam int CW = $clog2(MAX_SHIFT + 1);
  localparam logic [EXP_W-1:0] MAX_SHIFT_E = EXP_W'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, sa_q, sb_q, shift_b_q;
  logic [EXP_W-1:0]  e_q;
  logic [MW-1:0]     ma_q, mb_q;
  logic [CW-1:0]     cnt_q;

  logic [EXP_W-1:0]  exp_a_d, exp_b_d, ea_d, eb_d, diff_d;
  logic              a_ge_b_d;
  logic [CW-1:0]     cnt_init_d, step_d, cnt_next_d;
  logic [MW-1:0]     man_a_d, man_b_d, man_sel_d, lost_mask_d, man_shift_d;

  // Denormals (field 0) behave as exponent 1 with no hidden bit.
  assign exp_a_d = A[MAN_W +: EXP_W];
  assign exp_b_d = B[MAN_W +: EXP_W];
  assign ea_d    = (exp_a_d == '0) ? EXP_W'(1) : exp_a_d;
  assign eb_d    = (exp_b_d == '0) ? EXP_W'(1) : exp_b_d;
  assign man_a_d = {(exp_a_d != '0), A[MAN_W-1:0], 3'b000};
  assign man_b_d = {(exp_b_d != '0), B[MAN_W-1:0], 3'b000};

  assign a_ge_b_d   = (ea_d >= eb_d);
  assign diff_d     = a_ge_b_d ? (ea_d - eb_d) : (eb_d - ea_d);
  assign cnt_init_d = (diff_d > MAX_SHIFT_E) ? CW'(MAX_SHIFT) : diff_d[CW-1:0];

`ifdef ALIGN_STEP4_EN
  assign step_d = (cnt_q > CW'(4)) ? CW'(4) : cnt_q;
`else
  assign step_d = CW'(1);
`endif

  // Every bit pushed out of the LSB folds into the sticky position.
  assign man_sel_d   = shift_b_q ? mb_q : ma_q;
  assign lost_mask_d = ~({MW{1'b1}} << step_d);
  assign man_shift_d = (man_sel_d >> step_d) | MW'(|(man_sel_d & lost_mask_d));
  assign cnt_next_d  = cnt_q - step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      shift_b_q <= 1'b0;
      e_q       <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q      <= A[EXP_W+MAN_W];
            sb_q      <= B[EXP_W+MAN_W];
            e_q       <= a_ge_b_d ? ea_d : eb_d;
            ma_q      <= man_a_d;
            mb_q      <= man_b_d;
            cnt_q     <= cnt_init_d;
            shift_b_q <= a_ge_b_d;
            busy_q    <= 1'b1;
            if (cnt_init_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (shift_b_q) mb_q <= man_shift_d;
          else           ma_q <= man_shift_d;
          cnt_q <= cnt_next_d;
          if (cnt_next_d == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign SA   = sa_q;
  assign SB   = sb_q;
  assign E    = e_q;
  assign MA   = ma_q;
  assign MB   = mb_q;

endmodule

`default_nettype wire

// File: tb/tb_exp_aligner.sv
// ============================================================================
// tb_exp_aligner : scoreboard bench for exp_aligner against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exp_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        start = 1'b0;
  logic        busy, done, SA, SB;
  logic [7:0]  E;
  logic [26:0] MA, MB;

  exp_aligner #(.EXP_W(8), .MAN_W(23), .MAX_SHIFT(26)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .start(start),
    .busy(busy), .done(done), .SA(SA), .SB(SB), .E(E), .MA(MA), .MB(MB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sa, sb;
    logic [7:0]  e;
    logic [26:0] ma, mb;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t hold_x;
  logic hold_pending = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Align by plain integer arithmetic: shift right, OR any lost bits into bit 0.
  function automatic longint align(input longint m, input int sh);
    longint r;
    r = m >> sh;
    if ((m & ((64'd1 << sh) - 1)) != 0) r = r | 1;
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   x;
    int     ea, eb, sh;
    longint ma, mb;
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    ma = (longint'(a[30:23] != 0) << 26) + (longint'(a[22:0]) << 3);
    mb = (longint'(b[30:23] != 0) << 26) + (longint'(b[22:0]) << 3);
    sh = (ea > eb) ? ea - eb : eb - ea;
    if (sh > 26) sh = 26;
    if (ea > eb) mb = align(mb, sh);
    else if (eb > ea) ma = align(ma, sh);
    x.sa = a[31];
    x.sb = b[31];
    x.e  = 8'((ea > eb) ? ea : eb);
    x.ma = 27'(ma);
    x.mb = 27'(mb);
`ifdef ALIGN_STEP4_EN
    x.lat = (sh + 3) / 4;
`else
    x.lat = sh;
`endif
    x.start_edge = 0;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: reset checks on rst rise, result checks whenever done is seen.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sa_sb", {30'd0, SA, SB}, 0);
      chk("rst_e", 32'(E), 0);
      chk("rst_ma", 32'(MA), 0);
      chk("rst_mb", 32'(MB), 0);
      sb_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        hold_pending = 1'b0;
        chk("hold_e", 32'(E), 32'(hold_x.e));
        chk("hold_ma", 32'(MA), 32'(hold_x.ma));
        chk("hold_mb", 32'(MB), 32'(hold_x.mb));
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'(done), 0);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chk("latency", 32'(cyc), 32'(x.start_edge + x.lat));
          chk("sign", {30'd0, SA, SB}, {30'd0, x.sa, x.sb});
          chk("exp", 32'(E), 32'(x.e));
          chk("ma", 32'(MA), 32'(x.ma));
          chk("mb", 32'(MB), 32'(x.mb));
          chk("busy_in_done", 32'(busy), 1);
          hold_x = x;
          hold_pending = 1'b1;
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].start_edge + 40) begin
        chk("done_timeout", 32'(done), 1);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL busy_stuck: busy still 1 after %0d cycles", n);
      $fatal(1, "aborting");
    end
    @(posedge clk);
    #1;
    A = a;
    B = b;
    start = 1'b1;
    x = model(a, b);
    x.start_edge = cyc + 1;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_ignored(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] dir_a [9];
    logic [31:0] dir_b [9];
    dir_a = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800001, 32'h00000001,
              32'h00000000, 32'h80000000, 32'h7F800000, 32'h4B7FFFFF};
    dir_b = '{32'h3F800000, 32'hBF800000, 32'h4B800000, 32'h7F000000, 32'h00800000,
              32'h00000000, 32'h3F800000, 32'h00000001, 32'h3F800007};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i]);

    // Start re-pulsed during SHIFT, then during DONE; both must be ignored.
    issue(32'h40000000, 32'h3F800000);
    pulse_ignored(32'h12345678, 32'h7EDCBA98);
    issue(32'h3F800000, 32'hBF800000);
    pulse_ignored(32'h00000000, 32'h7F7FFFFF);

    for (int i = 0; i < 40; i++) begin
      int          ea, eb;
      logic [31:0] ra, rb;
      ea = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) eb = $urandom_range(0, 255);
      else begin
        eb = ea + $urandom_range(0, 60) - 30;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
      end
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      issue(ra, rb);
    end

    // Abort mid-SHIFT: outputs clear at once and no done may follow.
    issue(32'h3F800000, 32'h4B800000);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (35) @(posedge clk);

    issue(32'h3F800001, 32'h7F000000);
    begin
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
